// File: rtl/v_store_seq.sv
// Vector store sequencer: latches one store command and streams its elements to
// NUM_BANKS memory lanes, one element per lane per beat, under mem_ready backpressure.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 12
`endif

module v_store_seq #(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned MAX_LMUL  = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = `DATAMEM_BITS,
  localparam int unsigned DW       = MAX_LMUL * VLEN,
  localparam int unsigned MW       = DW / 8,
  localparam int unsigned VL_W     = $clog2(DW / 8) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [3:0]                           store_op,
  input  logic [2:0]                           lmul,
  input  logic [VL_W-1:0]                      vl,
  input  logic                                 vm,
  input  logic [MW-1:0]                        mask,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [ADDR_W-1:0]                    stride,
  input  logic [DW-1:0]                        data,
  input  logic                                 mem_ready,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]     data_addr,
  output logic [NUM_BANKS-1:0][WORD_W-1:0]     data_out,
  output logic [NUM_BANKS-1:0]                 data_we,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [3:0] VLSU_VSE8   = 4'd0;
  localparam logic [3:0] VLSU_VSE16  = 4'd1;
  localparam logic [3:0] VLSU_VSE32  = 4'd2;
  localparam logic [3:0] VLSU_VSSE8  = 4'd4;
  localparam logic [3:0] VLSU_VSSE16 = 4'd5;
  localparam logic [3:0] VLSU_VSSE32 = 4'd6;

  // Element index is one bit wider so lanes past the last element still compare cleanly.
  localparam int unsigned EW  = VL_W + 1;
  localparam int unsigned SHW = EW + 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         data_q;
  logic [MW-1:0]         mask_q;
  logic                  vm_q;
  logic [1:0]            sc_q;
  logic [VL_W-1:0]       n_q;
  logic [ADDR_W-1:0]     step_q;
  logic [EW-1:0]         elem_base_q;

  logic [1:0]            op_sc;
  logic                  op_strided;
  logic [1:0]            lsh;
  logic [VL_W-1:0]       vlmax;
  logic [VL_W-1:0]       op_n;
  logic [ADDR_W-1:0]     op_lane_step;

  logic                  accept;
  logic                  last_beat;
  logic [DW-1:0]         src_data;
  logic [MW-1:0]         src_mask;
  logic                  src_vm;
  logic [1:0]            src_sc;
  logic [VL_W-1:0]       src_n;
  logic [EW-1:0]         ebase;
  logic [ADDR_W-1:0]     addr_chain;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] lane_addr_d;
  logic [NUM_BANKS-1:0][WORD_W-1:0] lane_data_d;
  logic [NUM_BANKS-1:0]             lane_we_d;

  // Element idx of the payload at element size 8 << sc, sign-extended to a memory word.
  function automatic logic [WORD_W-1:0] elem(input logic [DW-1:0] d, input logic [1:0] sc,
                                            input logic [EW-1:0] idx);
    logic [SHW-1:0] amt;
    logic [31:0]    w;
    amt = (SHW'(idx) << 3) << sc;
    w   = 32'(d >> amt);
    case (sc)
      2'd0:    return WORD_W'($signed(w[7:0]));
      2'd1:    return WORD_W'($signed(w[15:0]));
      default: return WORD_W'($signed(w[31:0]));
    endcase
  endfunction

  // Command decode: element size, addressing mode and clamped element count.
  always_comb begin
    op_sc      = 2'd2;
    op_strided = 1'b0;
    lsh        = 2'd0;
    case (store_op)
      VLSU_VSE8:   op_sc = 2'd0;
      VLSU_VSE16:  op_sc = 2'd1;
      VLSU_VSE32:  op_sc = 2'd2;
      VLSU_VSSE8:  begin op_sc = 2'd0; op_strided = 1'b1; end
      VLSU_VSSE16: begin op_sc = 2'd1; op_strided = 1'b1; end
      VLSU_VSSE32: begin op_sc = 2'd2; op_strided = 1'b1; end
      default:     op_sc = 2'd2;
    endcase
    case (lmul)
      3'b001:  lsh = 2'd1;
      3'b010:  lsh = 2'd2;
      default: lsh = 2'd0;
    endcase
    vlmax        = VL_W'((VLEN / 8) << lsh) >> op_sc;
    op_n         = (vl < vlmax) ? vl : vlmax;
    op_lane_step = op_strided ? stride : ADDR_W'(1);
  end

  // Next state plus the lane values for the beat to present next.
  always_comb begin
    logic [EW-1:0] idx;
    logic [MW-1:0] msh;
    state_d    = state_q;
    accept     = 1'b0;
    last_beat  = (elem_base_q + EW'(NUM_BANKS)) >= EW'(n_q);
    src_data   = data_q;
    src_mask   = mask_q;
    src_vm     = vm_q;
    src_sc     = sc_q;
    src_n      = n_q;
    ebase      = elem_base_q + EW'(NUM_BANKS);
    addr_chain = base_addr;
    idx        = '0;
    msh        = '0;
    lane_addr_d = '0;
    lane_data_d = '0;
    lane_we_d   = '0;

    case (state_q)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_d  = (op_n != '0) ? RUN : DONE;
        src_data = data;
        src_mask = mask;
        src_vm   = vm;
        src_sc   = op_sc;
        src_n    = op_n;
        ebase    = '0;
      end
      RUN:     if (mem_ready && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int k = 0; k < int'(NUM_BANKS); k++) begin
      idx            = ebase + EW'(k);
      msh            = src_mask >> idx;
      lane_data_d[k] = elem(src_data, src_sc, idx);
      lane_we_d[k]   = (idx < EW'(src_n)) && (src_vm || msh[0]);
      lane_addr_d[k] = accept ? addr_chain : data_addr[k] + step_q;
      addr_chain     = addr_chain + op_lane_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_we     <= '0;
      data_addr   <= '0;
      data_out    <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      vm_q        <= 1'b0;
      sc_q        <= 2'd0;
      n_q         <= '0;
      step_q      <= '0;
      elem_base_q <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (accept) begin
        data_q      <= data;
        mask_q      <= mask;
        vm_q        <= vm;
        sc_q        <= op_sc;
        n_q         <= op_n;
        step_q      <= op_strided ? ADDR_W'(stride * NUM_BANKS) : ADDR_W'(NUM_BANKS);
        elem_base_q <= '0;
        data_addr   <= lane_addr_d;
        data_out    <= lane_data_d;
        data_we     <= lane_we_d;
      end else if (state_q == RUN && mem_ready) begin
        if (last_beat) begin
          data_we <= '0;
        end else begin
          elem_base_q <= elem_base_q + EW'(NUM_BANKS);
          data_addr   <= lane_addr_d;
          data_out    <= lane_data_d;
          data_we     <= lane_we_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_v_store_seq.sv
// Bench for v_store_seq: directed and random store commands checked beat by beat
// against an element-level reference model.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 12
`endif

module tb_v_store_seq;
  localparam int unsigned VLEN = 128, MAX_LMUL = 4, NB = 4, WORD_W = 32;
  localparam int unsigned ADDR_W = `DATAMEM_BITS;
  localparam int unsigned DW = MAX_LMUL * VLEN, MW = DW / 8, VL_W = $clog2(DW / 8) + 1;
  localparam int MAXB = 32, MAXC = 400;

  localparam logic [3:0] VSE8 = 4'd0, VSE16 = 4'd1, VSE32 = 4'd2;
  localparam logic [3:0] VSSE8 = 4'd4, VSSE16 = 4'd5, VSSE32 = 4'd6;

  logic clk = 1'b0;
  logic rst, start, vm, mem_ready;
  logic [3:0] store_op;
  logic [2:0] lmul;
  logic [VL_W-1:0] vl;
  logic [MW-1:0] mask;
  logic [ADDR_W-1:0] base_addr, stride;
  logic [DW-1:0] data;
  logic [NB-1:0][ADDR_W-1:0] data_addr;
  logic [NB-1:0][WORD_W-1:0] data_out;
  logic [NB-1:0] data_we;
  logic busy, done;

  always #5 clk = ~clk;

  v_store_seq #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL), .NUM_BANKS(NB), .WORD_W(WORD_W),
                .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .store_op(store_op), .lmul(lmul), .vl(vl),
    .vm(vm), .mask(mask), .base_addr(base_addr), .stride(stride), .data(data),
    .mem_ready(mem_ready), .data_addr(data_addr), .data_out(data_out),
    .data_we(data_we), .busy(busy), .done(done));

  int tests = 0, fails = 0;

  // Command under test
  logic [3:0] c_op; logic [2:0] c_lm; int c_vl; logic c_vm; logic [MW-1:0] c_mask;
  logic [ADDR_W-1:0] c_base, c_stride; logic [DW-1:0] c_data;

  logic [ADDR_W-1:0] exp_addr[MAXB][NB], obs_addr[MAXB][NB];
  logic [WORD_W-1:0] exp_data[MAXB][NB], obs_data[MAXB][NB];
  logic              exp_we[MAXB][NB],   obs_we[MAXB][NB];
  int exp_beats, obs_beats, done_c, last_acc_c, hold_diffs;
  logic [NB-1:0] done_we;
  logic busy_after;
  int ready_mode, stall_lo, stall_hi;
  bit spam;

  // Reference: every lane of every beat derived straight from the element rules.
  function automatic void model();
    int sew, lmn, vlmax, n, e, step;
    bit strided;
    logic [7:0] b8; logic [15:0] b16;
    sew = (c_op == VSE8 || c_op == VSSE8) ? 8 : (c_op == VSE16 || c_op == VSSE16) ? 16 : 32;
    strided = (c_op == VSSE8 || c_op == VSSE16 || c_op == VSSE32);
    lmn = (c_lm == 3'b001) ? 2 : (c_lm == 3'b010) ? 4 : 1;
    vlmax = lmn * int'(VLEN) / sew;
    n = (c_vl < vlmax) ? c_vl : vlmax;
    exp_beats = (n + NB - 1) / NB;
    step = strided ? int'(c_stride) : 1;
    for (int b = 0; b < exp_beats; b++)
      for (int k = 0; k < NB; k++) begin
        e = b * NB + k;
        exp_addr[b][k] = ADDR_W'(int'(c_base) + e * step);
        if (sew == 8) begin b8 = c_data[e*8 +: 8]; exp_data[b][k] = {{24{b8[7]}}, b8}; end
        else if (sew == 16) begin b16 = c_data[e*16 +: 16]; exp_data[b][k] = {{16{b16[15]}}, b16}; end
        else exp_data[b][k] = c_data[e*32 +: 32];
        exp_we[b][k] = (e < n) ? (c_vm || c_mask[e]) : 1'b0;
      end
  endfunction

  task automatic drive_cmd();
    @(negedge clk);
    store_op = c_op; lmul = c_lm; vl = VL_W'(c_vl); vm = c_vm; mask = c_mask;
    base_addr = c_base; stride = c_stride; data = c_data; mem_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes beats handshaken after accept; c counts cycles since the accept edge.
  task automatic collect();
    logic r, prev_r;
    logic [NB-1:0][ADDR_W-1:0] p_addr; logic [NB-1:0][WORD_W-1:0] p_out; logic [NB-1:0] p_we;
    obs_beats = 0; done_c = -1; last_acc_c = 0; hold_diffs = 0; prev_r = 1'b1;
    p_addr = '0; p_out = '0; p_we = '0; done_we = '1;
    for (int c = 1; c <= MAXC; c++) begin
      if (!prev_r && (data_addr !== p_addr || data_out !== p_out || data_we !== p_we))
        hold_diffs++;
      if (done) begin
        done_c = c; done_we = data_we; start = 1'b0; mem_ready = 1'b1;
        break;
      end
      if (ready_mode == 1) r = ($urandom_range(0, 3) != 0);
      else if (ready_mode == 2) r = !(c >= stall_lo && c < stall_hi);
      else r = 1'b1;
      mem_ready = r;
      if (spam) begin start = 1'($urandom_range(0, 1)); base_addr = ADDR_W'($urandom); end
      if (r) begin
        if (obs_beats < MAXB)
          for (int k = 0; k < NB; k++) begin
            obs_addr[obs_beats][k] = data_addr[k];
            obs_data[obs_beats][k] = data_out[k];
            obs_we[obs_beats][k] = data_we[k];
          end
        obs_beats++; last_acc_c = c;
      end
      p_addr = data_addr; p_out = data_out; p_we = data_we; prev_r = r;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b1; store_op = '0; lmul = '0; vl = '0; vm = 1'b1;
    mask = '0; base_addr = '0; stride = '0; data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, data_we} !== '0 || data_addr !== '0 || data_out !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b we=%b addr=%h out=%h, required all zero",
               busy, done, data_we, data_addr, data_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unit32();
    c_op = VSE32; c_lm = 3'b000; c_vl = 4; c_vm = 1'b1; c_mask = '0; c_base = 'h010;
    c_stride = '0; c_data = '0; c_data[127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
    ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    tests++;
    if (obs_beats !== 1 || done_c !== 2) begin
      fails++; $display("FAIL unit32_timing: beats=%0d done_c=%0d, required 1/2", obs_beats, done_c);
    end
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (obs_addr[0][k] !== ADDR_W'('h10 + k) || obs_data[0][k] !== 32'(k + 1) * 32'h11 ||
          obs_we[0][k] !== 1'b1) begin
        fails++;
        $display("FAIL unit32_lane%0d: addr=%h data=%h we=%b, required %h/%h/1", k,
                 obs_addr[0][k], obs_data[0][k], obs_we[0][k], 'h10 + k, (k + 1) * 'h11);
      end
    end
    tests++;
    if (done_we !== '0 || busy_after !== 1'b0) begin
      fails++; $display("FAIL unit32_done: we=%b busy_after=%b, required 0/0", done_we, busy_after);
    end
  endtask

  task automatic test_sign_ext();
    c_op = VSE8; c_lm = 3'b010; c_vl = 64; c_vm = 1'b1; c_mask = '0; c_base = 'h100;
    c_stride = '0;
    for (int i = 0; i < 64; i++) c_data[i*8 +: 8] = 8'(8'h80 + i);
    ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    tests++;
    if (obs_beats !== 16 || done_c !== 17 || obs_data[0][0] !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL vse8: beats=%0d done_c=%0d lane0=%h, required 16/17/ffffff80",
               obs_beats, done_c, obs_data[0][0]);
    end
    for (int b = 0; b < exp_beats; b++)
      for (int k = 0; k < NB; k++) begin
        tests++;
        if (obs_addr[b][k] !== exp_addr[b][k] || obs_data[b][k] !== exp_data[b][k] ||
            obs_we[b][k] !== exp_we[b][k]) begin
          fails++;
          $display("FAIL vse8_beat b=%0d k=%0d: %h/%h/%b, required %h/%h/%b", b, k,
                   obs_addr[b][k], obs_data[b][k], obs_we[b][k],
                   exp_addr[b][k], exp_data[b][k], exp_we[b][k]);
        end
      end
  endtask

  task automatic test_strided();
    logic [ADDR_W-1:0] want[NB];
    c_op = VSSE16; c_lm = 3'b000; c_vl = 5; c_vm = 1'b1; c_mask = '0; c_base = 'h020;
    c_stride = 'd3;
    for (int i = 0; i < int'(DW / 32); i++) c_data[i*32 +: 32] = $urandom;
    ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    want[0] = 'h20; want[1] = 'h23; want[2] = 'h26; want[3] = 'h29;
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (obs_addr[0][k] !== want[k] || obs_data[0][k] !== exp_data[0][k]) begin
        fails++;
        $display("FAIL strided_b0 k=%0d: addr=%h data=%h, required %h/%h", k,
                 obs_addr[0][k], obs_data[0][k], want[k], exp_data[0][k]);
      end
    end
    tests++;
    if (obs_beats !== 2 || obs_addr[1][0] !== ADDR_W'('h2C) ||
        {obs_we[1][3], obs_we[1][2], obs_we[1][1], obs_we[1][0]} !== 4'b0001) begin
      fails++;
      $display("FAIL strided_b1: beats=%0d addr0=%h we=%b%b%b%b, required 2/02c/0001", obs_beats,
               obs_addr[1][0], obs_we[1][3], obs_we[1][2], obs_we[1][1], obs_we[1][0]);
    end
  endtask

  task automatic test_mask();
    c_op = VSE32; c_lm = 3'b000; c_vl = 4; c_vm = 1'b0; c_base = 'h3F0; c_stride = '0;
    c_mask = {$urandom, $urandom}; c_mask[3:0] = 4'b1010;
    for (int i = 0; i < int'(DW / 32); i++) c_data[i*32 +: 32] = $urandom;
    ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    tests++;
    if ({obs_we[0][3], obs_we[0][2], obs_we[0][1], obs_we[0][0]} !== 4'b1010 || done_c !== 2) begin
      fails++;
      $display("FAIL mask: we(3..0)=%b%b%b%b done_c=%0d, required 1010/2", obs_we[0][3],
               obs_we[0][2], obs_we[0][1], obs_we[0][0], done_c);
    end
  endtask

  task automatic test_backpressure();
    c_op = VSE16; c_lm = 3'b000; c_vl = 8; c_vm = 1'b1; c_mask = '0; c_base = 'h7F8;
    c_stride = '0;
    for (int i = 0; i < int'(DW / 32); i++) c_data[i*32 +: 32] = $urandom;
    ready_mode = 2; stall_lo = 2; stall_hi = 5; spam = 1;
    model(); drive_cmd(); collect();
    spam = 0;
    tests++;
    if (obs_beats !== 2 || done_c !== 6 || hold_diffs !== 0 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL backpressure: beats=%0d done_c=%0d hold_diffs=%0d busy_after=%b, required 2/6/0/0",
               obs_beats, done_c, hold_diffs, busy_after);
    end
    for (int b = 0; b < exp_beats; b++)
      for (int k = 0; k < NB; k++) begin
        tests++;
        if (obs_addr[b][k] !== exp_addr[b][k] || obs_data[b][k] !== exp_data[b][k] ||
            obs_we[b][k] !== exp_we[b][k]) begin
          fails++;
          $display("FAIL backpressure_beat b=%0d k=%0d: %h/%h/%b, required %h/%h/%b", b, k,
                   obs_addr[b][k], obs_data[b][k], obs_we[b][k],
                   exp_addr[b][k], exp_data[b][k], exp_we[b][k]);
        end
      end
  endtask

  task automatic test_zero_vl();
    c_op = VSSE32; c_lm = 3'b001; c_vl = 0; c_vm = 1'b1; c_mask = '1; c_base = 'h055;
    c_stride = 'd7; ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    tests++;
    if (obs_beats !== 0 || done_c !== 1 || done_we !== '0 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL zero_vl: beats=%0d done_c=%0d we=%b busy_after=%b, required 0/1/0/0",
               obs_beats, done_c, done_we, busy_after);
    end
  endtask

  task automatic test_rst_mid();
    c_op = VSE32; c_lm = 3'b010; c_vl = 16; c_vm = 1'b1; c_mask = '0; c_base = 'h200;
    c_stride = '0;
    for (int i = 0; i < int'(DW / 32); i++) c_data[i*32 +: 32] = $urandom;
    drive_cmd();
    repeat (2) @(negedge clk);
    tests++;
    if (data_addr[0] !== ADDR_W'('h208) || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_beat2: addr0=%h busy=%b, required 208/1", data_addr[0], busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || data_we !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_after: busy=%b we=%b done=%b, required 0/0/0", busy, data_we, done);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_idle: busy=%b done=%b, required 0/0", busy, done);
    end
    c_base = 'h300; ready_mode = 0; spam = 0;
    model(); drive_cmd(); collect();
    tests++;
    if (obs_beats !== 4 || done_c !== 5) begin
      fails++; $display("FAIL rst_mid_restart: beats=%0d done_c=%0d, required 4/5", obs_beats, done_c);
    end
    for (int b = 0; b < exp_beats; b++)
      for (int k = 0; k < NB; k++) begin
        tests++;
        if (obs_addr[b][k] !== exp_addr[b][k] || obs_data[b][k] !== exp_data[b][k] ||
            obs_we[b][k] !== exp_we[b][k]) begin
          fails++;
          $display("FAIL rst_restart_beat b=%0d k=%0d: %h/%h/%b, required %h/%h/%b", b, k,
                   obs_addr[b][k], obs_data[b][k], obs_we[b][k],
                   exp_addr[b][k], exp_data[b][k], exp_we[b][k]);
        end
      end
  endtask

  task automatic test_random();
    logic [3:0] ops[7];
    ops[0] = VSE8; ops[1] = VSE16; ops[2] = VSE32; ops[3] = VSSE8; ops[4] = VSSE16;
    ops[5] = VSSE32; ops[6] = 4'hB;
    for (int t = 0; t < 40; t++) begin
      c_op = ops[$urandom_range(0, 6)]; c_lm = 3'($urandom_range(0, 7));
      c_vl = $urandom_range(0, 127); c_vm = 1'($urandom_range(0, 1));
      c_mask = {$urandom, $urandom}; c_base = ADDR_W'($urandom); c_stride = ADDR_W'($urandom);
      for (int i = 0; i < int'(DW / 32); i++) c_data[i*32 +: 32] = $urandom;
      ready_mode = 1; spam = 1'($urandom_range(0, 1));
      model(); drive_cmd(); collect();
      spam = 0;
      tests++;
      if (obs_beats !== exp_beats || done_c !== last_acc_c + 1 || done_we !== '0 ||
          busy_after !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_ctl: beats=%0d done_c=%0d we=%b busy_after=%b, required %0d/%0d/0/0",
                 t, obs_beats, done_c, done_we, busy_after, exp_beats, last_acc_c + 1);
      end
      for (int b = 0; b < exp_beats; b++)
        for (int k = 0; k < NB; k++) begin
          tests++;
          if (obs_addr[b][k] !== exp_addr[b][k] || obs_data[b][k] !== exp_data[b][k] ||
              obs_we[b][k] !== exp_we[b][k]) begin
            fails++;
            $display("FAIL rand%0d_beat b=%0d k=%0d: %h/%h/%b, required %h/%h/%b", t, b, k,
                     obs_addr[b][k], obs_data[b][k], obs_we[b][k],
                     exp_addr[b][k], exp_data[b][k], exp_we[b][k]);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_unit32();
    test_sign_ext();
    test_strided();
    test_mask();
    test_backpressure();
    test_zero_vl();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
